fml_bram_responder: RTL and testbench



---
 rtl/fml_pkg.sv | 15 +
 rtl/fml_bram_responder_if.sv | 26 ++
 rtl/fml_bram_32.sv | 27 ++
 rtl/fml_bram_responder.sv | 113 +++++++++++
 tb/tb_fml_bram_responder.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fml_pkg.sv
// Shared FML burst constants and responder state encoding.
package fml_pkg;

    localparam int unsigned FML_BURST_LEN      = 4;
    localparam int unsigned FML_BEAT_BYTES     = 4;
    localparam int unsigned FML_BURST_ADDR_LSB = 4;
    localparam int unsigned FML_BEAT_CNT_W     = $clog2(FML_BURST_LEN);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StBurst = 2'd2
    } fml_resp_state_e;

endpackage

// File: rtl/fml_bram_responder_if.sv
// FML burst bus: initiator drives request and write beats, responder returns ack and read beats.
interface fml_bram_responder_if
    import fml_pkg::*;
#(
    parameter int unsigned g_fml_depth = 26
);

    logic [g_fml_depth-1:0]      fml_adr;
    logic                        fml_stb;
    logic                        fml_we;
    logic [FML_BEAT_BYTES-1:0]   fml_sel;
    logic [8*FML_BEAT_BYTES-1:0] fml_di;
    logic [8*FML_BEAT_BYTES-1:0] fml_do;
    logic                        fml_ack;

    modport master (
        output fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        input  fml_do, fml_ack
    );

    modport slave (
        input  fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        output fml_do, fml_ack
    );

endinterface

// File: rtl/fml_bram_32.sv
// Single-port 32-bit RAM with per-byte write enables and registered read data.
module fml_bram_32
    import fml_pkg::*;
#(
    parameter int unsigned g_words_log2 = 12
) (
    input  logic                        clk_sys_i,
    input  logic [g_words_log2-1:0]     addr,
    input  logic                        we,
    input  logic [FML_BEAT_BYTES-1:0]   sel,
    input  logic [8*FML_BEAT_BYTES-1:0] wdata,
    output logic [8*FML_BEAT_BYTES-1:0] rdata
);

    logic [8*FML_BEAT_BYTES-1:0] mem [2**g_words_log2];

    // Read-first: rdata returns the old word when the same address is written.
    always_ff @(posedge clk_sys_i) begin
        for (int b = 0; b < int'(FML_BEAT_BYTES); b++) begin
            if (we && sel[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fml_bram_responder.sv
// FML target serving fixed 4-beat bursts from block RAM with programmable ack latency and
// back-pressure.
module fml_bram_responder
    import fml_pkg::*;
#(
    parameter int unsigned g_fml_depth      = 26,
    parameter int unsigned g_mem_words_log2 = 12,
    parameter int unsigned g_ack_latency    = 2
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_i,
    fml_bram_responder_if.slave  fml,
    input  logic                 stall_i,
    output logic                 busy_o
);

    localparam int unsigned MemAw = g_mem_words_log2;

    typedef logic [MemAw-1:0] word_addr_t;

    fml_resp_state_e           state_q;
    logic [3:0]                lat_q;
    logic [FML_BEAT_CNT_W-1:0] beat_q;
    word_addr_t                base_q;
    logic                      we_q;

    word_addr_t                req_base;
    word_addr_t                ram_addr;
    logic                      ack;
    logic                      beat_active;
    logic                      ram_we;
    logic [31:0]               ram_rdata;
    logic                      unused_adr_bits;

    // Burst-aligned word index; address bits outside the memory alias away.
    assign req_base = {fml.fml_adr[MemAw+1:FML_BURST_ADDR_LSB], {FML_BEAT_CNT_W{1'b0}}};
    assign unused_adr_bits = ^{fml.fml_adr[FML_BURST_ADDR_LSB-1:0],
                               fml.fml_adr[g_fml_depth-1:MemAw+2]};

    assign ack = (state_q == StWait) && (lat_q == 4'd0) && !stall_i && fml.fml_stb && !rst_i;

    // The ack cycle is beat 0 of the burst even though the state register still reads WAIT.
    assign beat_active = ack || (state_q == StBurst);
    assign ram_we      = beat_active && we_q && !rst_i;

    assign fml.fml_ack = ack;
    assign fml.fml_do  = (beat_active && !we_q && !rst_i) ? ram_rdata : '0;
    assign busy_o      = (state_q != StIdle);

    // Reads run one word ahead of the current beat to cover the RAM's registered output.
    always_comb begin
        ram_addr = base_q;
        unique case (state_q)
            StIdle:  ram_addr = req_base;
            StWait:  ram_addr = ack ? base_q + word_addr_t'(!we_q) : base_q;
            StBurst: ram_addr = base_q + word_addr_t'(beat_q) + word_addr_t'(!we_q);
            default: ram_addr = base_q;
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            lat_q   <= 4'd0;
            beat_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fml.fml_stb) begin
                        base_q  <= req_base;
                        we_q    <= fml.fml_we;
                        lat_q   <= 4'(g_ack_latency - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!fml.fml_stb) begin
                        state_q <= StIdle;
                        lat_q   <= 4'd0;
                    end else if (ack) begin
                        state_q <= StBurst;
                        beat_q  <= FML_BEAT_CNT_W'(1);
                    end else if (lat_q != 4'd0) begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                StBurst: begin
                    if (beat_q == FML_BEAT_CNT_W'(FML_BURST_LEN - 1)) begin
                        state_q <= StIdle;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + FML_BEAT_CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fml_bram_32 #(
        .g_words_log2(g_mem_words_log2)
    ) u_ram (
        .clk_sys_i(clk_sys_i),
        .addr     (ram_addr),
        .we       (ram_we),
        .sel      (fml.fml_sel),
        .wdata    (fml.fml_di),
        .rdata    (ram_rdata)
    );

endmodule

// File: tb/tb_fml_bram_responder.sv
// Bench for fml_bram_responder: table of bursts, scoreboard for read beats, hand-coded corners.
module tb_fml_bram_responder;

    localparam int unsigned Lat = 2;

    logic clk_sys_i = 1'b0;
    logic rst_i;
    logic stall_i;
    logic busy_o;

    always #5 clk_sys_i = ~clk_sys_i;

    fml_bram_responder_if #(.g_fml_depth(26)) fml ();

    fml_bram_responder #(
        .g_fml_depth     (26),
        .g_mem_words_log2(12),
        .g_ack_latency   (Lat)
    ) dut (
        .clk_sys_i(clk_sys_i),
        .rst_i    (rst_i),
        .fml      (fml),
        .stall_i  (stall_i),
        .busy_o   (busy_o)
    );

    typedef struct {
        logic [25:0]       adr;
        logic              we;
        logic [3:0][31:0]  data;   // write beats, or expected read beats
        logic [3:0][3:0]   ws;
        int                stall_n;
        int                exp_lat;
    } vec_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] sb_q[$];
    logic        cur_we = 1'b1;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %08h required %08h at %0t", nm, act, exp, $time);
    endtask

    function automatic vec_t mkv(input logic [25:0] adr, input logic we,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3,
                                 input logic [3:0] s0, input logic [3:0] srest,
                                 input int stall_n, input int exp_lat);
        vec_t v;
        v.adr     = adr;
        v.we      = we;
        v.data[0] = d0;
        v.data[1] = d1;
        v.data[2] = d2;
        v.data[3] = d3;
        v.ws[0]   = s0;
        v.ws[1]   = srest;
        v.ws[2]   = srest;
        v.ws[3]   = srest;
        v.stall_n = stall_n;
        v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk_sys_i);
        #1;
    endtask

    // One complete burst starting in the next cycle; read beats are checked by the monitor.
    task automatic burst(input vec_t v);
        int t;
        cyc();
        fml.fml_adr = v.adr;
        fml.fml_we  = v.we;
        fml.fml_stb = 1'b1;
        fml.fml_di  = v.we ? v.data[0] : 32'h0;
        fml.fml_sel = v.ws[0];
        stall_i     = (v.stall_n > 0);
        cur_we      = v.we;
        if (!v.we) for (int k = 0; k < 4; k++) sb_q.push_back(v.data[k]);
        t = 0;
        while (1'b1) begin
            @(negedge clk_sys_i);
            if (fml.fml_ack || t >= 40) break;
            cyc();
            t++;
            stall_i = (t < v.stall_n);
        end
        chk("ack_latency", 32'(t), 32'(v.exp_lat));
        if (!fml.fml_ack) begin
            fml.fml_stb = 1'b0;
            stall_i     = 1'b0;
            sb_q.delete();
            return;
        end
        for (int k = 1; k < 4; k++) begin
            cyc();
            fml.fml_stb = 1'b0;
            stall_i     = 1'b0;
            fml.fml_di  = v.we ? v.data[k] : 32'h0;
            fml.fml_sel = v.ws[k];
            @(negedge clk_sys_i);
            chk("ack_single_cycle", 32'(fml.fml_ack), 32'd0);
        end
        cyc();
        fml.fml_di  = 32'h0;
        fml.fml_sel = 4'h0;
        @(negedge clk_sys_i);
        chk("busy_after_burst", 32'(busy_o), 32'd0);
    endtask

    // Read beats follow each ack for four cycles; fml_do must be zero at all other times.
    initial begin
        int mon_k;
        mon_k = 4;
        forever begin
            @(negedge clk_sys_i);
            if (mon_en) begin
                if (fml.fml_ack) mon_k = 0;
                else if (mon_k < 4) mon_k++;
                if (mon_k < 4 && !cur_we) begin
                    if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                    else chk("rd_beat", fml.fml_do, sb_q.pop_front());
                end else begin
                    chk("do_idle_zero", fml.fml_do, 32'h0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vec_t vecs[11];
        vec_t v;
        int   t;
        int   nack;
        int   last;
        int   cnt;
        bit   acked;

        rst_i       = 1'b1;
        stall_i     = 1'b0;
        fml.fml_adr = '0;
        fml.fml_stb = 1'b0;
        fml.fml_we  = 1'b0;
        fml.fml_sel = 4'h0;
        fml.fml_di  = 32'h0;

        repeat (3) cyc();
        @(negedge clk_sys_i);
        chk("reset_ack", 32'(fml.fml_ack), 32'd0);
        chk("reset_do", fml.fml_do, 32'h0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        cyc();
        rst_i = 1'b0;
        @(negedge clk_sys_i);
        chk("post_reset_busy", 32'(busy_o), 32'd0);
        mon_en = 1'b1;

        vecs[0]  = mkv(26'h40, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                       4'hF, 4'hF, 0, Lat);
        vecs[1]  = mkv(26'h40, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                       4'h0, 4'h0, 0, Lat);
        vecs[2]  = mkv(26'h80, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF, 0, Lat);
        vecs[3]  = mkv(26'h80, 1'b1, 32'hAABBCCDD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                       4'b0101, 4'h0, 0, Lat);
        vecs[4]  = mkv(26'h80, 1'b0, 32'h00BB00DD, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, Lat);
        vecs[5]  = mkv(26'h40, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                       4'h0, 4'h0, 10, 10);
        vecs[6]  = mkv(26'h10040, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333,
                       32'h44444444, 4'h0, 4'h0, 0, Lat);
        vecs[7]  = mkv(26'h4C, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                       4'h0, 4'h0, 3, 3);
        vecs[8]  = mkv(26'h3FF0, 1'b1, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3,
                       4'hF, 4'hF, 0, Lat);
        vecs[9]  = mkv(26'h3FF0, 1'b0, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3,
                       4'h0, 4'h0, 1, Lat);
        vecs[10] = mkv(26'h0, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                       4'h0, 4'h0, 0, Lat);
        // Row 10 reads word 0 region aliased from 0x4000 + 0x40 below; patch the address.
        vecs[10].adr = 26'h4040;

        for (int i = 0; i < 11; i++) burst(vecs[i]);

        // Abort: write request withdrawn after one cycle must leave memory untouched.
        cyc();
        fml.fml_adr = 26'h40;
        fml.fml_we  = 1'b1;
        fml.fml_stb = 1'b1;
        fml.fml_di  = 32'hDEADBEEF;
        fml.fml_sel = 4'hF;
        cur_we      = 1'b1;
        @(negedge clk_sys_i);
        chk("abort_ack_t0", 32'(fml.fml_ack), 32'd0);
        cyc();
        fml.fml_stb = 1'b0;
        @(negedge clk_sys_i);
        chk("abort_busy_wait", 32'(busy_o), 32'd1);
        chk("abort_ack_t1", 32'(fml.fml_ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk_sys_i);
            chk("abort_ack_after", 32'(fml.fml_ack), 32'd0);
            chk("abort_busy_after", 32'(busy_o), 32'd0);
        end
        fml.fml_di  = 32'h0;
        fml.fml_sel = 4'h0;
        burst(mkv(26'h40, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                  4'h0, 4'h0, 0, Lat));

        // Back-to-back reads with stb held high across eight bursts.
        for (int i = 0; i < 8; i++) begin
            v = mkv(26'(32'h200 + 32'(16 * i)), 1'b1, 32'hC0DE0000 + 32'(4 * i),
                    32'hC0DE0001 + 32'(4 * i), 32'hC0DE0002 + 32'(4 * i),
                    32'hC0DE0003 + 32'(4 * i), 4'hF, 4'hF, 0, Lat);
            burst(v);
        end
        for (int i = 0; i < 32; i++) sb_q.push_back(32'hC0DE0000 + 32'(i));
        cyc();
        cur_we      = 1'b0;
        fml.fml_we  = 1'b0;
        fml.fml_adr = 26'h200;
        fml.fml_stb = 1'b1;
        nack = 0;
        last = 0;
        cnt  = 0;
        while (nack < 8 && cnt < 200) begin
            @(negedge clk_sys_i);
            acked = fml.fml_ack;
            if (acked) begin
                if (nack == 0) chk("b2b_first_latency", 32'(cnt), 32'(Lat));
                else chk("b2b_ack_spacing", 32'(cnt - last), 32'(4 + Lat));
                last = cnt;
                nack++;
            end
            cyc();
            cnt++;
            if (acked) begin
                fml.fml_adr = fml.fml_adr + 26'h10;
                if (nack == 8) fml.fml_stb = 1'b0;
            end
        end
        fml.fml_stb = 1'b0;
        chk("b2b_ack_count", 32'(nack), 32'd8);
        repeat (4) cyc();
        chk("b2b_sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset during write beat 2: beats 0-1 land, beats 2-3 keep their old contents.
        burst(mkv(26'h300, 1'b1, 32'h51515151, 32'h52525252, 32'h53535353, 32'h54545454,
                  4'hF, 4'hF, 0, Lat));
        cyc();
        fml.fml_adr = 26'h300;
        fml.fml_we  = 1'b1;
        fml.fml_stb = 1'b1;
        fml.fml_di  = 32'hE0E0E0E0;
        fml.fml_sel = 4'hF;
        cur_we      = 1'b1;
        t = 0;
        while (1'b1) begin
            @(negedge clk_sys_i);
            if (fml.fml_ack || t >= 40) break;
            cyc();
            t++;
        end
        chk("rst_burst_latency", 32'(t), 32'(Lat));
        cyc();
        fml.fml_stb = 1'b0;
        fml.fml_di  = 32'hE1E1E1E1;
        cyc();
        fml.fml_di  = 32'hE2E2E2E2;
        rst_i       = 1'b1;
        @(negedge clk_sys_i);
        chk("rst_cycle_ack", 32'(fml.fml_ack), 32'd0);
        cyc();
        rst_i       = 1'b0;
        fml.fml_di  = 32'hE3E3E3E3;
        @(negedge clk_sys_i);
        chk("rst_next_ack", 32'(fml.fml_ack), 32'd0);
        chk("rst_next_busy", 32'(busy_o), 32'd0);
        chk("rst_next_do", fml.fml_do, 32'h0);
        fml.fml_di  = 32'h0;
        fml.fml_sel = 4'h0;
        burst(mkv(26'h300, 1'b0, 32'hE0E0E0E0, 32'hE1E1E1E1, 32'h53535353, 32'h54545454,
                  4'h0, 4'h0, 0, Lat));

        repeat (2) cyc();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
